// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcodes, datapath select encodings
// and the packed control word for the multicycle MIPS control unit.
// Optional feature macro: MIPS_CTRL_JUMP_EN (adds the j instruction / JUMP state).
package mips_ctrl_pkg;

  // FSM states; encodings are visible on state_o for debug.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd15
  } state_e;

  // Opcode field values (instruction bits [31:26]).
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALU operation request to the ALU control block.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // ALU B operand select.
  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SL2 = 2'b11
  } srcb_e;

  // Next-PC source select.
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  // Every datapath control driven by the unit, as one word.
  typedef struct packed {
    logic   iord;
    logic   mem_read;
    logic   mem_write;
    logic   ir_write;
    logic   pc_write;
    logic   pc_write_cond;
    logic   alu_src_a;
    logic   reg_dst;
    logic   mem_to_reg;
    logic   reg_write;
    srcb_e  alu_src_b;
    aluop_e alu_op;
    pcsrc_e pc_source;
    logic   trap;
  } ctrl_t;

  // True in the cycle whose closing edge retires an instruction.
  function automatic logic is_retiring(input state_e s, input logic mem_rdy);
    logic r;
    r = 1'b0;
    case (s)
      S_MEMWB, S_ALUWB, S_BRANCH: r = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP:                     r = 1'b1;
`endif
      S_MEMWR:                    r = mem_rdy;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: Moore output decoder, (state, mem_rdy) -> control word.
// Optional feature macro: MIPS_CTRL_JUMP_EN (JUMP state outputs).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e i_state,
  input  logic   i_mem_rdy,
  output ctrl_t  o_ctrl
);

  // Decode the current state into datapath controls; unlisted controls stay 0.
  always_comb begin
    // NOTE: assigning the whole word first means no path leaves a field
    // unassigned, so no latch can be inferred.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.iord      = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        // IR and PC are only updated once the instruction word is valid.
        o_ctrl.ir_write  = i_mem_rdy;
        o_ctrl.pc_write  = i_mem_rdy;
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm << 2) into ALUOut.
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM_SL2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        // Held for every wait cycle until the memory accepts the write.
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
`endif
      S_TRAP: begin
        o_ctrl.trap = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM. Holds the state register,
// next-state logic and the retired-instruction counter; outputs come from
// mips_ctrl_outdec and depend only on state and mem_rdy.
// Optional feature macro: MIPS_CTRL_JUMP_EN (opcode 2 -> JUMP instead of TRAP).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic             mem_rdy,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             ALUSrcA,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;
  ctrl_t            w_ctrl;

  assign w_retire = is_retiring(r_state, mem_rdy);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: reset is asynchronous so the datapath controls drop to 0 the
    // moment rst falls; no clock is needed to abandon an instruction.
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; run is only looked at in IDLE and when retiring.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (run) w_state_nxt = S_FETCH;
      S_FETCH:  if (mem_rdy) w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_state_nxt = S_MEMADR;
          OP_RTYPE:     w_state_nxt = S_EXEC;
          OP_BEQ:       w_state_nxt = S_BRANCH;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:         w_state_nxt = S_JUMP;
`endif
          default:      w_state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      w_state_nxt = S_MEMRD;
        else if (op == OP_SW) w_state_nxt = S_MEMWR;
        else                  w_state_nxt = S_TRAP;
      end
      S_MEMRD:  if (mem_rdy) w_state_nxt = S_MEMWB;
      S_EXEC:   w_state_nxt = S_ALUWB;
`ifdef MIPS_CTRL_JUMP_EN
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: begin
`else
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH: begin
`endif
        if (w_retire) w_state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_TRAP:   w_state_nxt = S_TRAP;
      // Unused encodings are treated as a fault and parked in TRAP.
      default:  w_state_nxt = S_TRAP;
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  mips_ctrl_outdec u_outdec (
    .i_state   (r_state),
    .i_mem_rdy (mem_rdy),
    .o_ctrl    (w_ctrl)
  );

  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign RegDst      = w_ctrl.reg_dst;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign trap        = w_ctrl.trap;
  assign state_o     = r_state;
  assign retired     = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven bench for mips_multicycle_ctrl with a
// retire scoreboard, plus hand sequences for reset, run/stop, trap and wrap.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, mem_rdy;
  logic [5:0]  op;
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic        ALUSrcA, RegDst, MemtoReg, RegWrite, trap;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state_o;
  logic [31:0] retired;

  // Small-counter instance used only for the wrap check.
  logic        rst4, run4, rdy4;
  logic [5:0]  op4;
  logic        a4, b4, c4, d4, e4, f4, g4, h4, i4, j4, trap4;
  logic [1:0]  srcb4, aluop4, pcsrc4;
  logic [3:0]  state4;
  logic [3:0]  retired4;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .mem_rdy(mem_rdy),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ALUSrcA(ALUSrcA),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state_o(state_o), .trap(trap), .retired(retired)
  );

  mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .run(run4), .op(op4), .mem_rdy(rdy4),
    .IorD(a4), .MemRead(b4), .MemWrite(c4), .IRWrite(d4),
    .PCWrite(e4), .PCWriteCond(f4), .ALUSrcA(g4),
    .RegDst(h4), .MemtoReg(i4), .RegWrite(j4),
    .ALUSrcB(srcb4), .ALUOp(aluop4), .PCSource(pcsrc4),
    .state_o(state4), .trap(trap4), .retired(retired4)
  );

  logic [16:0] w_ctrl;
  assign w_ctrl = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
                   ALUSrcA, RegDst, MemtoReg, RegWrite, ALUSrcB, ALUOp,
                   PCSource, trap};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Expected control word written straight from the state output table.
  // Bit order: IorD MemRead MemWrite IRWrite PCWrite PCWriteCond ALUSrcA
  //            RegDst MemtoReg RegWrite | ALUSrcB | ALUOp | PCSource | trap
  function automatic logic [16:0] ref_ctrl(input logic [3:0] st, input logic rdy);
    logic [16:0] c;
    c = '0;
    case (st)
      4'd1:  c = {1'b0, 1'b1, 1'b0, rdy, rdy, 5'b00000, 2'b01, 2'b00, 2'b00, 1'b0};
      4'd2:  c = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
      4'd3:  c = {10'b0000001000, 2'b10, 2'b00, 2'b00, 1'b0};
      4'd4:  c = {10'b1100000000, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd5:  c = {10'b0000000011, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd6:  c = {10'b1010000000, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd7:  c = {10'b0000001000, 2'b00, 2'b10, 2'b00, 1'b0};
      4'd8:  c = {10'b0000000101, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd9:  c = {10'b0000011000, 2'b00, 2'b01, 2'b01, 1'b0};
      4'd10: c = {10'b0000100000, 2'b00, 2'b00, 2'b10, 1'b0};
      4'd15: c = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

  // One instruction: per-cycle states, mem_rdy and run, listed LSB-first
  // (nibble/bit 0 is the FETCH cycle).
  typedef struct {
    string       name;
    logic [5:0]  op;
    int          n;
    logic [39:0] st;
    logic [9:0]  rdy;
    logic [9:0]  runb;
    bit          retires;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [5:0] o, input int n,
                              input logic [39:0] st, input logic [9:0] rdy,
                              input logic [9:0] rn, input bit ret);
    vec_t v;
    v.name = nm; v.op = o; v.n = n; v.st = st; v.rdy = rdy; v.runb = rn; v.retires = ret;
    return v;
  endfunction

  vec_t        tbl[$];
  logic [31:0] sb_q[$];
  logic [31:0] exp_ret  = 0;
  logic [31:0] last_ret = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction from FETCH and check every cycle against the table.
  task automatic apply(input vec_t v);
    op = v.op;
    if (v.retires) begin
      exp_ret = exp_ret + 1;
      sb_q.push_back(exp_ret);
    end
    for (int k = 0; k < v.n; k++) begin
      mem_rdy = v.rdy[k];
      run     = v.runb[k];
      #1;
      check({v.name, " state"}, {28'd0, state_o}, {28'd0, v.st[4*k +: 4]});
      check({v.name, " ctrl"}, {15'd0, w_ctrl}, {15'd0, ref_ctrl(v.st[4*k +: 4], v.rdy[k])});
      step();
    end
  endtask

  // Scoreboard: every change of retired must match the next expected count.
  always @(negedge clk) begin
    if (rst && retired !== last_ret) begin
      if (sb_q.size() == 0) check("unexpected retire", retired, last_ret);
      else                  check("retired", retired, sb_q.pop_front());
      last_ret = retired;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vectors with run=1 throughout unless noted.
    tbl.push_back(mk("add",        6'd0,  4, 40'h0000008721, 10'h3FF,       10'h3FF,       1));
    tbl.push_back(mk("lw",         6'd35, 5, 40'h0000054321, 10'h3FF,       10'h3FF,       1));
    tbl.push_back(mk("sw",         6'd43, 4, 40'h0000006321, 10'h3FF,       10'h3FF,       1));
    tbl.push_back(mk("beq",        6'd4,  3, 40'h0000000921, 10'h3FF,       10'h3FF,       1));
    tbl.push_back(mk("add_rdy_lo", 6'd0,  4, 40'h0000008721, 10'b0000000001, 10'h3FF,      1));
    tbl.push_back(mk("lw_wait2",   6'd35, 7, 40'h0005444321, 10'b1111100111, 10'h3FF,      1));
    tbl.push_back(mk("sw_wait2",   6'd43, 6, 40'h0000666321, 10'b1111100111, 10'h3FF,      1));
    tbl.push_back(mk("beq_b2b",    6'd4,  3, 40'h0000000921, 10'h3FF,       10'h3FF,       1));
    tbl.push_back(mk("add_fwait",  6'd0,  5, 40'h0000087211, 10'b1111111110, 10'h3FF,      1));
    tbl.push_back(mk("add_stop",   6'd0,  4, 40'h0000008721, 10'h3FF,       10'b0000000011, 1));

    // Reset state and asynchronous reset in the middle of a FETCH wait.
    rst = 1'b0; run = 1'b0; op = 6'd0; mem_rdy = 1'b0;
    rst4 = 1'b0; run4 = 1'b1; op4 = 6'd4; rdy4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {28'd0, state_o}, 32'd0);
    check("reset ctrl", {15'd0, w_ctrl}, 32'd0);
    check("reset retired", retired, 32'd0);
    rst = 1'b1; run = 1'b1;
    step();
    check("fetch after reset", {28'd0, state_o}, 32'd1);
    check("fetch wait ctrl", {15'd0, w_ctrl}, {15'd0, ref_ctrl(4'd1, 1'b0)});
    step();
    check("fetch hold", {28'd0, state_o}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async rst state", {28'd0, state_o}, 32'd0);
    check("async rst ctrl", {15'd0, w_ctrl}, 32'd0);
    check("async rst retired", retired, 32'd0);
    #1 rst = 1'b1;
    last_ret = retired;
    mem_rdy  = 1'b1;
    step();
    check("fetch after release", {28'd0, state_o}, 32'd1);

    // Table-driven instruction sequences.
    foreach (tbl[i]) apply(tbl[i]);

    // run was dropped in EXEC of add_stop: unit must sit in IDLE.
    for (int i = 0; i < 3; i++) begin
      check("idle hold", {28'd0, state_o}, 32'd0);
      check("idle ctrl", {15'd0, w_ctrl}, 32'd0);
      step();
    end
    run = 1'b1;
    step();
    check("resume fetch", {28'd0, state_o}, 32'd1);

`ifdef MIPS_CTRL_JUMP_EN
    apply(mk("jump", 6'd2, 3, 40'h0000000A21, 10'h3FF, 10'h3FF, 1));
    apply(mk("illegal", 6'd63, 3, 40'h0000000F21, 10'h3FF, 10'h3FF, 0));
`else
    apply(mk("j_trap", 6'd2, 3, 40'h0000000F21, 10'h3FF, 10'h3FF, 0));
`endif

    // TRAP is sticky regardless of run and mem_rdy.
    for (int i = 0; i < 10; i++) begin
      mem_rdy = i[0];
      #1;
      check("trap state", {28'd0, state_o}, 32'd15);
      check("trap flag", {31'd0, trap}, 32'd1);
      check("trap retired", retired, exp_ret);
      step();
    end
    #1 rst = 1'b0;
    #1;
    check("trap cleared", {31'd0, trap}, 32'd0);
    check("trap rst state", {28'd0, state_o}, 32'd0);
    check("trap rst retired", retired, 32'd0);
    #1 rst = 1'b1;
    last_ret = retired;
    exp_ret  = 0;
    mem_rdy  = 1'b1;
    step();
    check("fetch after trap", {28'd0, state_o}, 32'd1);
    check("scoreboard drained", sb_q.size(), 32'd0);

    // Counter wrap on the 4-bit instance: back-to-back beq.
    rst4 = 1'b1;
    for (int i = 0; i < 200 && retired4 != 4'd15; i++) step();
    check("cnt4 at max", {28'd0, retired4}, 32'd15);
    repeat (2) step();
    check("cnt4 hold", {28'd0, retired4}, 32'd15);
    step();
    check("cnt4 wrap", {28'd0, retired4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
